// File: rtl/keypad_pkg.sv
// Shared helpers for the matrix keypad scanner: the "no key" code and
// the mapping from 4x3 scan codes to the legacy digit/control values.
package keypad_pkg;

  // All-ones value of the given width, used as the "no key" code.
  function automatic logic [31:0] key_none(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  // 4x3 layout: rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#.
  // Returns 0-9 for digits, 10 for '*', 11 for '#', 12 for none/invalid.
  function automatic logic [3:0] code_to_digit(input logic [3:0] code);
    if (code <= 4'd8) return code + 4'd1;
    case (code)
      4'd9:    return 4'd10;
      4'd10:   return 4'd0;
      4'd11:   return 4'd11;
      default: return 4'd12;
    endcase
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Turns one key result per scan frame into a debounced stable key and
// press / release / auto-repeat event strobes.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int CODE_W   = 4,
  parameter int DEBOUNCE = 2,
  parameter int REPEAT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  logic [CODE_W-1:0] frame_result,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held
);

  localparam logic [31:0] NONE32 = key_none(CODE_W);
  localparam logic [CODE_W-1:0] KEY_NONE = NONE32[CODE_W-1:0];
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int REP_W = $clog2(REPEAT + 2);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT > 0) ? REPEAT - 1 : 0);

  logic [CODE_W-1:0] cand_reg, cand_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CODE_W-1:0] stable_reg, stable_next;
  logic              pend_reg, pend_next;
  logic [CODE_W-1:0] pend_code_reg, pend_code_next;
  logic [REP_W-1:0]  rep_reg, rep_next;
  logic              valid_reg, valid_next;
  logic              release_reg, release_next;

  // State register for candidate, stable key, repeat counter and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg      <= KEY_NONE;
      cnt_reg       <= '0;
      stable_reg    <= KEY_NONE;
      pend_reg      <= 1'b0;
      pend_code_reg <= KEY_NONE;
      rep_reg       <= '0;
      valid_reg     <= 1'b0;
      release_reg   <= 1'b0;
    end else begin
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      stable_reg    <= stable_next;
      pend_reg      <= pend_next;
      pend_code_reg <= pend_code_next;
      rep_reg       <= rep_next;
      valid_reg     <= valid_next;
      release_reg   <= release_next;
    end
  end

  // Debounce / event decision. A direct K->J change is split over two
  // cycles: release of K first, press of J from the pending slot next.
  // A pending press can never coincide with frame_done because a frame
  // is at least four cycles long.
  always_comb begin
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    stable_next    = stable_reg;
    pend_next      = 1'b0;
    pend_code_next = pend_code_reg;
    rep_next       = rep_reg;
    valid_next     = 1'b0;
    release_next   = 1'b0;
    if (pend_reg) begin
      stable_next = pend_code_reg;
      valid_next  = 1'b1;
      rep_next    = '0;
    end else if (frame_done) begin
      if (frame_result == cand_reg) begin
        cnt_next = (cnt_reg == DEB_MAX) ? cnt_reg : cnt_reg + 1'b1;
      end else begin
        cand_next = frame_result;
        cnt_next  = CNT_W'(1);
      end
      if (cnt_next == DEB_MAX && cand_next != stable_reg) begin
        rep_next = '0;
        if (stable_reg == KEY_NONE) begin
          stable_next = cand_next;
          valid_next  = 1'b1;
        end else if (cand_next == KEY_NONE) begin
          stable_next  = KEY_NONE;
          release_next = 1'b1;
        end else begin
          release_next   = 1'b1;
          pend_next      = 1'b1;
          pend_code_next = cand_next;
        end
      end else if (REPEAT > 0 && stable_reg != KEY_NONE) begin
        if (rep_reg == REP_LAST) begin
          rep_next   = '0;
          valid_next = 1'b1;
        end else begin
          rep_next = rep_reg + 1'b1;
        end
      end
    end
  end

  assign key_code    = stable_reg;
  assign key_valid   = valid_reg;
  assign key_release = release_reg;
  assign key_held    = (stable_reg != KEY_NONE);

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column synchroniser, row strobe sequencer and
// per-frame key accumulator feeding the frame debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2,
  parameter int REPEAT   = 0,
  localparam int CODE_W  = $clog2(ROWS * COLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   key_col,
  output logic [ROWS-1:0]   key_row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              key_multi
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [31:0] NONE32 = key_none(CODE_W);
  localparam logic [CODE_W-1:0] KEY_NONE = NONE32[CODE_W-1:0];

  logic [COLS-1:0]   col_meta_reg, col_sync_reg, col_ord;
  logic [DIV_W-1:0]  div_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              active_reg;
  logic [1:0]        hits_reg;
  logic [CODE_W-1:0] acc_code_reg;
  logic              frame_done_reg;
  logic [CODE_W-1:0] frame_result_reg;
  logic              multi_reg;

  logic [1:0]        slot_hits, hits_total;
  logic [2:0]        hits_sum;
  logic [COL_W-1:0]  slot_col;
  logic [CODE_W-1:0] slot_code, acc_code_next, frame_value;
  logic              sample, frame_end;

  // Column c of the code space is pin key_col[COLS-1-c]; row r drives
  // key_row[ROWS-1-r]. Rows stay dark until the first cycle after reset.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign col_ord[gi] = col_sync_reg[COLS-1-gi];
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign key_row[ROWS-1-gi] = active_reg && (row_reg == ROW_W'(gi));
    end
  endgenerate

  // Count active columns in the current slot (saturating at two) and
  // remember the lowest active column.
  always_comb begin
    slot_hits = '0;
    slot_col  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_ord[c]) begin
        if (slot_hits == 2'd0) slot_col = COL_W'(c);
        if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
      end
    end
  end

  assign slot_code     = CODE_W'(int'(row_reg) * COLS + int'(slot_col));
  assign hits_sum      = {1'b0, hits_reg} + {1'b0, slot_hits};
  assign hits_total    = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
  assign acc_code_next = (hits_reg == 2'd0 && slot_hits == 2'd1) ? slot_code : acc_code_reg;
  assign frame_value   = (hits_total == 2'd1) ? acc_code_next : KEY_NONE;
  assign sample        = active_reg && (div_reg == DIV_LAST);
  assign frame_end     = sample && (row_reg == ROW_LAST);

  // Synchroniser, scan counters and frame accumulator; columns are only
  // sampled in the last cycle of each row slot to let the lines settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_reg     <= '0;
      col_sync_reg     <= '0;
      div_reg          <= '0;
      row_reg          <= '0;
      active_reg       <= 1'b0;
      hits_reg         <= '0;
      acc_code_reg     <= KEY_NONE;
      frame_done_reg   <= 1'b0;
      frame_result_reg <= KEY_NONE;
      multi_reg        <= 1'b0;
    end else begin
      col_meta_reg   <= key_col;
      col_sync_reg   <= col_meta_reg;
      active_reg     <= 1'b1;
      frame_done_reg <= 1'b0;
      if (active_reg) begin
        div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
      if (sample) begin
        row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        if (frame_end) begin
          frame_done_reg   <= 1'b1;
          frame_result_reg <= frame_value;
          multi_reg        <= (hits_total == 2'd2);
          hits_reg         <= '0;
          acc_code_reg     <= KEY_NONE;
        end else begin
          hits_reg     <= hits_total;
          acc_code_reg <= acc_code_next;
        end
      end
    end
  end

  assign key_multi = multi_reg;

  keypad_frame_debounce #(
    .CODE_W  (CODE_W),
    .DEBOUNCE(DEBOUNCE),
    .REPEAT  (REPEAT)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_done  (frame_done_reg),
    .frame_result(frame_result_reg),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release),
    .key_held    (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a table of keypad hold patterns
// on a default instance, plus an auto-repeat / mid-hold reset sequence.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int NV = 15;
  localparam int FRAME = 16;

  typedef struct {
    logic [11:0] mask;
    int frames;
    int nv;
    int nr;
    int code;
    int held;
    int multi;
    int vcode;
    int rcode;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  logic [11:0] mask, mask2;
  logic [2:0] key_col, key_col2;
  logic [3:0] key_row, key_row2, key_code, key_code2;
  logic key_valid, key_release, key_held, key_multi;
  logic key_valid2, key_release2, key_held2, key_multi2;

  int errors = 0;
  int checks = 0;
  vec_t tbl[NV];
  int vc[NV], rc[NV], vcode[NV], rcode[NV], vcyc[NV], rcyc[NV], rowbad[NV];
  int excl_bad = 0;
  int idx;
  logic [3:0] row_exp;
  int cnt2, first2, last2, rel2, pulses_rst, pulses_after;

  // Keypad matrix: a pressed key (r,c) pulls column pin 2-c high while
  // its row strobe key_row[3-r] is active.
  function automatic logic [2:0] col_model(input logic [11:0] m, input logic [3:0] rows);
    logic [2:0] c;
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 3; cc++)
        if (m[r*3+cc] && rows[3-r]) c[2-cc] = 1'b1;
    return c;
  endfunction

  assign key_col  = col_model(mask, key_row);
  assign key_col2 = col_model(mask2, key_row2);

  keypad_scanner u_dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_held(key_held), .key_multi(key_multi)
  );

  keypad_scanner #(.REPEAT(3)) u_rep (
    .clk(clk), .rst(rst2), .key_col(key_col2), .key_row(key_row2),
    .key_code(key_code2), .key_valid(key_valid2), .key_release(key_release2),
    .key_held(key_held2), .key_multi(key_multi2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input int v);
    $display("vec %0d mask=%03h frames=%0d valid=%0d release=%0d code=%0d held=%0d multi=%0d",
             v, tbl[v].mask, tbl[v].frames, vc[v], rc[v], key_code, key_held, key_multi);
    check($sformatf("v%0d_valid_count", v), vc[v], tbl[v].nv);
    check($sformatf("v%0d_release_count", v), rc[v], tbl[v].nr);
    check($sformatf("v%0d_key_code", v), int'(key_code), tbl[v].code);
    check($sformatf("v%0d_key_held", v), int'(key_held), tbl[v].held);
    check($sformatf("v%0d_key_multi", v), int'(key_multi), tbl[v].multi);
    check($sformatf("v%0d_row_seq_errors", v), rowbad[v], 0);
    if (tbl[v].vcode >= 0) check($sformatf("v%0d_valid_code", v), vcode[v], tbl[v].vcode);
    if (tbl[v].rcode >= 0) check($sformatf("v%0d_release_code", v), rcode[v], tbl[v].rcode);
  endtask

  task automatic observe(input int k, input int i);
    if (key_valid) begin
      vc[k]++;
      vcode[k] = int'(key_code);
      vcyc[k]  = i;
    end
    if (key_release) begin
      rc[k]++;
      rcode[k] = int'(key_code);
      rcyc[k]  = i;
    end
    if (key_valid && key_release) excl_bad++;
  endtask

  initial begin
    //            mask     frm nv nr code held multi vcode rcode
    tbl[0]  = '{12'h000, 5, 0, 0, 15, 0, 0, -1, -1};  // idle
    tbl[1]  = '{12'h010, 4, 1, 0,  4, 1, 0,  4, -1};  // press 4
    tbl[2]  = '{12'h000, 3, 0, 1, 15, 0, 0, -1, 15};  // release
    tbl[3]  = '{12'h010, 1, 0, 0, 15, 0, 0, -1, -1};  // bounce
    tbl[4]  = '{12'h000, 1, 0, 0, 15, 0, 0, -1, -1};
    tbl[5]  = '{12'h010, 1, 0, 0, 15, 0, 0, -1, -1};
    tbl[6]  = '{12'h010, 3, 1, 0,  4, 1, 0,  4, -1};  // settles on 4
    tbl[7]  = '{12'h000, 3, 0, 1, 15, 0, 0, -1, 15};
    tbl[8]  = '{12'h021, 3, 0, 0, 15, 0, 1, -1, -1};  // keys 0+5
    tbl[9]  = '{12'h001, 3, 1, 0,  0, 1, 0,  0, -1};  // drop 5
    tbl[10] = '{12'h000, 3, 0, 1, 15, 0, 0, -1, 15};
    tbl[11] = '{12'h018, 2, 0, 0, 15, 0, 1, -1, -1};  // keys 3+4 same row
    tbl[12] = '{12'h004, 3, 1, 0,  2, 1, 0,  2, -1};  // press 2
    tbl[13] = '{12'h400, 3, 1, 1, 10, 1, 0, 10,  2};  // 2 -> 10 directly
    tbl[14] = '{12'h000, 3, 0, 1, 15, 0, 0, -1, 15};
    for (int v = 0; v < NV; v++) begin
      vc[v] = 0; rc[v] = 0; vcode[v] = -1; rcode[v] = -1;
      vcyc[v] = -1; rcyc[v] = -1; rowbad[v] = 0;
    end

    rst = 1'b1; rst2 = 1'b1; mask = '0; mask2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_row", int'(key_row), 0);
    check("rst_key_code", int'(key_code), 15);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_release", int'(key_release), 0);
    check("rst_key_held", int'(key_held), 0);
    check("rst_key_multi", int'(key_multi), 0);

    rst = 1'b0;
    @(negedge clk);
    // Each vector starts on the first cycle of a frame; events of the
    // previous vector's last frame land within the first three cycles.
    for (int v = 0; v < NV; v++) begin
      mask = tbl[v].mask;
      for (int i = 0; i < tbl[v].frames * FRAME; i++) begin
        idx = (i < 3 && v > 0) ? v - 1 : v;
        row_exp = 4'b1000;
        row_exp = row_exp >> ((i / 4) % 4);
        if (key_row != row_exp) rowbad[v]++;
        observe(idx, i);
        if (i == 3 && v > 0) check_vec(v - 1);
        @(negedge clk);
      end
    end
    for (int i = 0; i < 3; i++) begin
      observe(NV - 1, i);
      @(negedge clk);
    end
    check_vec(NV - 1);

    check("kj_valid_follows_release", vcyc[13] - rcyc[13], 1);
    check("valid_release_exclusive", excl_bad, 0);
    check("digit_of_4", int'(code_to_digit(4'd4)), 5);
    check("digit_of_9", int'(code_to_digit(4'd9)), 10);
    check("digit_of_10", int'(code_to_digit(4'd10)), 0);
    check("digit_of_11", int'(code_to_digit(4'd11)), 11);
    check("digit_of_none", int'(code_to_digit(4'd15)), 12);

    // Auto-repeat: hold key 7 from the first frame after reset.
    rst2 = 1'b0;
    @(negedge clk);
    check("rep_first_row", int'(key_row2), 8);
    mask2 = 12'h080;
    cnt2 = 0; first2 = -1; last2 = -1; rel2 = 0;
    for (int i = 0; i <= 14 * FRAME + 1; i++) begin
      if (key_valid2) begin
        cnt2++;
        if (cnt2 == 1) first2 = i;
        last2 = i;
        if (key_code2 != 4'd7) excl_bad++;
      end
      if (key_release2) rel2++;
      @(negedge clk);
    end
    $display("repeat hold key7: valid pulses=%0d first=%0d last=%0d releases=%0d",
             cnt2, first2, last2, rel2);
    check("rep_valid_count", cnt2, 5);
    check("rep_first_cycle", first2, 33);
    check("rep_last_cycle", last2, 225);
    check("rep_no_release", rel2, 0);
    check("rep_code_held", int'(key_code2), 7);
    check("rep_held", int'(key_held2), 1);
    check("rep_code_at_pulses", excl_bad, 0);

    // Reset in the middle of a hold: straight to reset values, no pulses.
    rst2 = 1'b1;
    pulses_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (key_valid2 || key_release2) pulses_rst++;
    end
    $display("mid-hold reset: row=%b code=%0d held=%0d pulses=%0d",
             key_row2, key_code2, key_held2, pulses_rst);
    check("mid_rst_pulses", pulses_rst, 0);
    check("mid_rst_key_row", int'(key_row2), 0);
    check("mid_rst_key_code", int'(key_code2), 15);
    check("mid_rst_key_held", int'(key_held2), 0);
    check("mid_rst_key_multi", int'(key_multi2), 0);
    rst2 = 1'b0;
    @(negedge clk);
    check("post_rst_row0", int'(key_row2), 8);
    pulses_after = 0;
    for (int i = 0; i < 31; i++) begin
      if (key_valid2 || key_release2) pulses_after++;
      @(negedge clk);
    end
    $display("after reset, key still held: pulses in first 31 cycles=%0d", pulses_after);
    check("post_rst_no_early_pulse", pulses_after, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that supersedes the fixed 4x3 scanner. It drives one-hot row strobes and samples synchronised column inputs. Each full scan frame is reduced to a single key result, debounced over several frames, and emitted as press/release event strobes with an optional auto-repeat. It sits between the keypad pins and the digit-entry/control logic, which consumes key_valid/key_code rather than a level-coded key.

Parameters:
ROWS, 4, number of row strobes (>=2)
COLS, 3, number of column inputs (>=2)
SCAN_DIV, 4, clock cycles each row is held active (>=2)
DEBOUNCE, 2, consecutive identical frame results required to change the stable key (>=1)
REPEAT, 0, frames between repeat key_valid pulses while a key is held (0 = auto-repeat off)
CODE_W, $clog2(ROWS*COLS+1), key code width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_col  in  COLS  raw column lines, active high, asynchronous to clk
key_row  out  ROWS  one-hot row strobe, active high
key_code  out  CODE_W  stable key code; KEY_NONE (all ones) when no key
key_valid  out  1  one-cycle pulse: press or repeat of key_code
key_release  out  1  one-cycle pulse: stable key returned to none or changed
key_held  out  1  level: stable key != KEY_NONE
key_multi  out  1  level: last completed frame saw more than one key

Behaviour:
- Clock is clk; reset rst is synchronous and active-high. All state updates on posedge clk only.
- Reset values: key_row=0, key_code=KEY_NONE, key_valid=0, key_release=0, key_held=0, key_multi=0. Clears the synchroniser, div counter, row index, frame accumulator, debounce counter and repeat counter.
- key_col passes a 2-flop synchroniser before any use.
- Scan: row index r counts 0..ROWS-1 and wraps; div counter counts 0..SCAN_DIV-1.
- Row r drives key_row[ROWS-1-r]. Column c is key_col[COLS-1-c]. The first cycle after reset release drives row 0.
- Sampling: the synchronised columns are sampled only on the last cycle of each row slot (div==SCAN_DIV-1). The earlier cycles are settling time.
- Code = r*COLS + c, range 0..ROWS*COLS-1.
- Frame result, computed when the last slot of row ROWS-1 closes:
  - exactly one active (row,col) in the whole frame -> that code
  - none active -> KEY_NONE
  - two or more active (same row or different rows) -> KEY_NONE, and key_multi=1 for the next frame period; otherwise key_multi=0.
- Debounce:
  - Frame result == candidate -> count++, saturating.
  - Frame result differs -> candidate=result, count=1.
  - When count reaches DEBOUNCE and candidate != stable, stable takes candidate the cycle after frame end.
- Events on a stable change:
  - NONE->K: key_valid=1 and key_code=K in the same cycle.
  - K->NONE: key_release=1; key_code becomes NONE in the same cycle.
  - K->J directly: key_release in cycle t (key_code still K), then key_code=J and key_valid in cycle t+1.
- key_held mirrors stable != NONE.
- Auto-repeat (REPEAT>0): while stable key is held, key_valid pulses again at each frame end where the frames since the last pulse equal REPEAT. The repeat counter clears on any stable change.
- key_valid and key_release are never high in the same cycle.
- Press-to-key_valid latency = 2 sync cycles + remainder of the current frame + (DEBOUNCE-1) frames + 1.
- A reset asserted mid-frame discards the partial frame. No event pulses are generated by reset.

Decomposition:
- Package keypad_pkg:
  - function key_none(CODE_W) returning all ones
  - function code_to_digit mapping 4x3 codes to the legacy values 0-9, 10 (*), 11 (#), 12 (none)
- Sub-module keypad_frame_debounce (CODE_W, DEBOUNCE, REPEAT):
  - inputs: frame_done strobe and frame result
  - holds candidate/stable/repeat logic and generates key_valid/key_release/key_code
- The top module keeps the synchroniser, scan counters and frame accumulator.

Test Plan:
(Defaults, frame = 16 cycles.)
- Reset, no key for 5 frames -> key_row cycles 1000,0100,0010,0001 every 4 cycles; key_code=7'b? all ones (4'hF); no pulses.
- Hold row1/col1 (code 4) for 4 frames -> exactly one key_valid with key_code=4 after the 2nd clean frame; key_held=1. Release -> one key_release after 2 clean frames; key_code=4'hF.
- Key 4 bounces (alternates each frame) for 3 frames, then holds -> no event during the bounce; one key_valid (code 4) after 2 stable frames.
- Keys 0 and 5 held together -> key_multi=1, no key_valid; drop key 5 -> key_valid with code 0 after 2 frames.
- Hold 2, then switch directly to 10 -> key_release (key_code=2), next cycle key_valid (key_code=10); code_to_digit(10)=0.
- REPEAT=3, hold key 7 for 12 frames -> initial key_valid, then one every 3 frames (4 total repeats counted at the 12-frame bound); rst mid-hold -> outputs at reset values, no pulse.
